// File: rtl/comm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comm_pkg
// Brief    : Constants and types shared by the host-link receive path.
// Revision : 1.0
// ============================================================================
package comm_pkg;

    localparam int ADDR_W         = 12;
    localparam int FRAME_WORDS    = 768;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } packer_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_word_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_packer_if
// Brief    : Byte input and frame-RAM write bundle of the word packer.
// Revision : 1.0
// ============================================================================
interface uart_word_packer_if #(
    parameter int ADDR_W = comm_pkg::ADDR_W
) ();

    logic              START;
    logic              STOP;
    logic              RX_VALID;
    logic [7:0]        RX_DATA;
    logic              WR_EN;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [31:0]       WR_DATA;
    logic              ACTIVE;
    logic              FRAME_DONE;
    logic              BYTE_ERR;

    modport master (
        output START, STOP, RX_VALID, RX_DATA,
        input  WR_EN, WR_ADDR, WR_DATA, ACTIVE, FRAME_DONE, BYTE_ERR
    );

    modport slave (
        input  START, STOP, RX_VALID, RX_DATA,
        output WR_EN, WR_ADDR, WR_DATA, ACTIVE, FRAME_DONE, BYTE_ERR
    );

endinterface
`default_nettype wire

// File: rtl/uart_word_packer_byte_timer.sv
`default_nettype none
// ============================================================================
// Module   : byte_timer
// Brief    : Clearable idle counter; o_tc marks the TIMEOUT_CYC-th enabled cycle.
// Revision : 1.0
// ============================================================================
module byte_timer #(
    parameter int TIMEOUT_CYC = 8680
) (
    input  wire logic CLOCK,
    input  wire logic RESET,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_tc
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_TC    = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_count;

    assign o_tc = i_en && (r_count == c_TC);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_count <= '0;
        end else if (i_clr || o_tc) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_packer
// Brief    : Packs UART bytes LSB-first into 32-bit words and fills one frame of RAM.
// Revision : 1.0
// ============================================================================
module uart_word_packer #(
    parameter int ADDR_W      = comm_pkg::ADDR_W,
    parameter int FRAME_WORDS = comm_pkg::FRAME_WORDS,
    parameter int TIMEOUT_CYC = 8680
) (
    input  wire logic          CLOCK,
    input  wire logic          RESET,
    uart_word_packer_if.slave  link
);

    import comm_pkg::packer_state_t;
    import comm_pkg::IDLE;
    import comm_pkg::COLLECT;
    import comm_pkg::BYTES_PER_WORD;

    localparam int                  c_LANE_W    = $clog2(BYTES_PER_WORD);
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0]   c_LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    packer_state_t       r_state;
    packer_state_t       w_state_next;
    logic [c_LANE_W-1:0] r_lane;
    logic [c_LANE_W-1:0] w_lane_eff;
    logic [31:0]         r_word;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wr_data;
    logic                r_wr_en;
    logic                r_frame_done;
    logic                r_byte_err;
    logic                w_collect;
    logic                w_start;
    logic                w_accept;
    logic                w_tc;
    logic                w_timeout;
    logic                w_write;
    logic                w_last;
    logic                w_tmr_clr;
    logic                w_tmr_en;

    byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_byte_timer (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_collect    = (r_state == COLLECT);
        w_start      = (r_state == IDLE) && link.START && !link.STOP;
        w_accept     = w_collect && link.RX_VALID && !link.STOP;
        w_timeout    = w_tc && !link.STOP;
        // A byte arriving on the expiry cycle starts a fresh word.
        w_lane_eff   = w_timeout ? '0 : r_lane;
        w_write      = w_accept && (w_lane_eff == c_LAST_LANE);
        w_last       = w_write && (r_addr == c_LAST_ADDR);
        w_tmr_clr    = w_accept || !w_collect || link.STOP;
        w_tmr_en     = w_collect && (r_lane != '0);
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = COLLECT;
            COLLECT: if (link.STOP || w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_lane       <= '0;
            r_word       <= '0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_byte_err   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wr_en      <= w_write;
            r_frame_done <= w_last;
            r_byte_err   <= w_timeout;

            // Shifting in from the top leaves {b3,b2,b1,b0} after four bytes.
            if (w_accept) begin
                r_word <= {link.RX_DATA, r_word[31:8]};
            end
            if (w_write) begin
                r_wr_data <= {link.RX_DATA, r_word[31:8]};
            end

            if (w_start || link.STOP) begin
                r_lane <= '0;
            end else if (w_accept) begin
                r_lane <= w_lane_eff + 1'b1;
            end else if (w_timeout) begin
                r_lane <= '0;
            end

            // Address advances the cycle after the strobe so WR_ADDR matches WR_EN.
            if (w_start || link.STOP) begin
                r_addr <= '0;
            end else if (r_wr_en) begin
                r_addr <= r_frame_done ? '0 : r_addr + 1'b1;
            end
        end
    end

    assign link.WR_EN      = r_wr_en;
    assign link.WR_ADDR    = r_addr;
    assign link.WR_DATA    = r_wr_data;
    assign link.ACTIVE     = (r_state == COLLECT);
    assign link.FRAME_DONE = r_frame_done;
    assign link.BYTE_ERR   = r_byte_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_word_packer
// Brief    : Directed self-checking bench for uart_word_packer.
// Revision : 1.0
// ============================================================================
module tb_uart_word_packer;

    localparam int ADDR_W      = 12;
    localparam int FRAME_WORDS = 768;
    localparam int TIMEOUT_CYC = 8680;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_word_packer_if #(.ADDR_W(ADDR_W)) bus ();

    uart_word_packer #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLOCK (clk),
        .RESET (rst),
        .link  (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Write / pulse log, sampled on the falling edge
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                fd_cnt  = 0;
    int                fd_nowr = 0;
    int                err_cnt = 0;
    logic [ADDR_W-1:0] fd_addr = '0;

    always @(negedge clk) begin
        if (bus.WR_EN === 1'b1) begin
            wa_q.push_back(bus.WR_ADDR);
            wd_q.push_back(bus.WR_DATA);
        end
        if (bus.FRAME_DONE === 1'b1) begin
            fd_cnt++;
            fd_addr = bus.WR_ADDR;
            if (bus.WR_EN !== 1'b1) fd_nowr++;
        end
        if (bus.BYTE_ERR === 1'b1) err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        @(negedge clk);
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = b;
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        bus.START    = 1'b0;
        bus.STOP     = 1'b0;
        repeat (n - 1) @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        bus.START    = 1'b1;
        @(negedge clk);
        bus.START    = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        bus.STOP     = 1'b1;
        @(negedge clk);
        bus.STOP     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++;
        if ({bus.WR_EN, bus.FRAME_DONE, bus.BYTE_ERR, bus.ACTIVE} !== 4'b0)
            $display("FAIL reset_flags: got %b required 0000", {bus.WR_EN, bus.FRAME_DONE, bus.BYTE_ERR, bus.ACTIVE});
        else pass_cnt++;
        total_cnt++;
        if (bus.WR_ADDR !== '0 || bus.WR_DATA !== 32'h0)
            $display("FAIL reset_addr_data: got %h/%h required 0/0", bus.WR_ADDR, bus.WR_DATA);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        int base = wa_q.size();
        int e0   = err_cnt;
        @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START    = 1'b0;
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = 8'h11;
        #1;
        total_cnt++;
        if (bus.ACTIVE !== 1'b1) $display("FAIL single_active: got %b required 1", bus.ACTIVE);
        else pass_cnt++;
        put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        #1;
        total_cnt++;
        if (bus.WR_EN !== 1'b1 || bus.WR_ADDR !== 12'd0 || bus.WR_DATA !== 32'h44332211)
            $display("FAIL single_write: got en=%b addr=%0d data=%h required en=1 addr=0 data=44332211",
                     bus.WR_EN, bus.WR_ADDR, bus.WR_DATA);
        else pass_cnt++;
        settle();
        total_cnt++;
        if (bus.WR_EN !== 1'b0 || bus.WR_ADDR !== 12'd1 || bus.WR_DATA !== 32'h44332211)
            $display("FAIL single_after: got en=%b addr=%0d data=%h required en=0 addr=1 data=44332211",
                     bus.WR_EN, bus.WR_ADDR, bus.WR_DATA);
        else pass_cnt++;
        total_cnt++;
        if (wa_q.size() - base != 1 || err_cnt != e0)
            $display("FAIL single_counts: got writes=%0d errs=%0d required 1/0", wa_q.size() - base, err_cnt - e0);
        else pass_cnt++;
        pulse_stop();
        settle();
        total_cnt++;
        if (bus.ACTIVE !== 1'b0 || bus.WR_ADDR !== 12'd0)
            $display("FAIL single_stop: got active=%b addr=%0d required 0/0", bus.ACTIVE, bus.WR_ADDR);
        else pass_cnt++;
    endtask

    task automatic test_full_frame();
        int base = wa_q.size();
        int f0   = fd_cnt;
        int nw0  = fd_nowr;
        int n;
        int bad  = 0;
        logic [31:0] exp_w;
        pulse_start();
        for (int i = 0; i < FRAME_WORDS * 4; i++) put_byte(8'(i));
        go_idle(4);
        n = wa_q.size() - base;
        total_cnt++;
        if (n != FRAME_WORDS) $display("FAIL frame_count: got %0d required %0d", n, FRAME_WORDS);
        else pass_cnt++;
        if (n >= FRAME_WORDS) begin
            for (int j = 0; j < FRAME_WORDS; j++) begin
                exp_w = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
                if (wa_q[base+j] !== ADDR_W'(j) || wd_q[base+j] !== exp_w) bad++;
            end
            total_cnt++;
            if (bad != 0) $display("FAIL frame_words: got %0d bad words required 0", bad);
            else pass_cnt++;
            total_cnt++;
            if (wd_q[base+FRAME_WORDS-1] !== 32'hFFFEFDFC)
                $display("FAIL frame_last_word: got %h required fffefdfc", wd_q[base+FRAME_WORDS-1]);
            else pass_cnt++;
        end
        total_cnt++;
        if (fd_cnt - f0 != 1 || fd_addr !== 12'd767 || fd_nowr != nw0)
            $display("FAIL frame_done: got pulses=%0d addr=%0d lone=%0d required 1/767/0",
                     fd_cnt - f0, fd_addr, fd_nowr - nw0);
        else pass_cnt++;
        total_cnt++;
        if (bus.ACTIVE !== 1'b0 || bus.WR_ADDR !== 12'd0)
            $display("FAIL frame_idle: got active=%b addr=%0d required 0/0", bus.ACTIVE, bus.WR_ADDR);
        else pass_cnt++;
        n = wa_q.size();
        for (int i = 0; i < 8; i++) put_byte(8'hE0 + 8'(i));
        go_idle(3);
        total_cnt++;
        if (wa_q.size() != n) $display("FAIL frame_extra: got %0d writes required 0", wa_q.size() - n);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int base = wa_q.size();
        int e0   = err_cnt;
        int k    = 0;
        pulse_start();
        put_byte(8'hAA);
        put_byte(8'hBB);
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        #1;
        while (bus.BYTE_ERR !== 1'b1 && k < TIMEOUT_CYC + 20) begin
            @(negedge clk); #1;
            k++;
        end
        total_cnt++;
        if (k != TIMEOUT_CYC) $display("FAIL timeout_latency: got %0d required %0d", k, TIMEOUT_CYC);
        else pass_cnt++;
        settle();
        total_cnt++;
        if (err_cnt - e0 != 1 || wa_q.size() != base || bus.WR_ADDR !== 12'd0)
            $display("FAIL timeout_discard: got errs=%0d writes=%0d addr=%0d required 1/0/0",
                     err_cnt - e0, wa_q.size() - base, bus.WR_ADDR);
        else pass_cnt++;
        put_byte(8'h01); put_byte(8'h02); put_byte(8'h03); put_byte(8'h04);
        go_idle(3);
        total_cnt++;
        if (wa_q.size() - base != 1 || wa_q[base] !== 12'd0 || wd_q[base] !== 32'h04030201)
            $display("FAIL timeout_next_word: got n=%0d data=%h required 1 word 04030201 at 0",
                     wa_q.size() - base, (wd_q.size() > base) ? wd_q[base] : 32'hx);
        else pass_cnt++;
        // Byte landing exactly on the expiry cycle opens a new word
        put_byte(8'hCC);
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        repeat (TIMEOUT_CYC - 2) @(negedge clk);
        put_byte(8'h05); put_byte(8'h06); put_byte(8'h07); put_byte(8'h08);
        go_idle(3);
        total_cnt++;
        if (err_cnt - e0 != 2 || wa_q.size() - base != 2 || wa_q[base+1] !== 12'd1 || wd_q[base+1] !== 32'h08070605)
            $display("FAIL timeout_coincide: got errs=%0d n=%0d data=%h required 2/2/08070605",
                     err_cnt - e0, wa_q.size() - base, wd_q[wd_q.size()-1]);
        else pass_cnt++;
        pulse_stop();
    endtask

    task automatic test_stop();
        int base = wa_q.size();
        int e0   = err_cnt;
        int f0   = fd_cnt;
        pulse_start();
        for (int i = 0; i < 6; i++) put_byte(8'h21 + 8'(i));
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        bus.STOP     = 1'b1;
        @(negedge clk);
        bus.STOP     = 1'b0;
        bus.RX_VALID = 1'b1;
        bus.RX_DATA  = 8'h99;
        #1;
        total_cnt++;
        if (bus.ACTIVE !== 1'b0) $display("FAIL stop_active: got %b required 0", bus.ACTIVE);
        else pass_cnt++;
        go_idle(3);
        total_cnt++;
        if (wa_q.size() - base != 1 || wa_q[base] !== 12'd0 || wd_q[base] !== 32'h24232221 ||
            err_cnt != e0 || fd_cnt != f0)
            $display("FAIL stop_partial: got n=%0d errs=%0d fd=%0d required 1/0/0",
                     wa_q.size() - base, err_cnt - e0, fd_cnt - f0);
        else pass_cnt++;
        pulse_start();
        put_byte(8'h31); put_byte(8'h32); put_byte(8'h33); put_byte(8'h34);
        go_idle(3);
        total_cnt++;
        if (wa_q.size() - base != 2 || wa_q[base+1] !== 12'd0 || wd_q[base+1] !== 32'h34333231)
            $display("FAIL stop_restart: got n=%0d addr=%0d required 2 writes, 34333231 at 0",
                     wa_q.size() - base, wa_q[wa_q.size()-1]);
        else pass_cnt++;
        pulse_stop();
    endtask

    task automatic test_start_stop();
        int base = wa_q.size();
        @(negedge clk);
        bus.START = 1'b1;
        bus.STOP  = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        #1;
        total_cnt++;
        if (bus.ACTIVE !== 1'b0) $display("FAIL start_stop_active: got %b required 0", bus.ACTIVE);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) put_byte(8'h70 + 8'(i));
        go_idle(3);
        total_cnt++;
        if (wa_q.size() != base) $display("FAIL start_stop_writes: got %0d required 0", wa_q.size() - base);
        else pass_cnt++;
    endtask

    task automatic test_restart_ignored();
        int base = wa_q.size();
        pulse_start();
        for (int i = 0; i < 20; i++) put_byte(8'(i + 1));
        pulse_start();
        put_byte(8'hC1); put_byte(8'hC2); put_byte(8'hC3); put_byte(8'hC4);
        go_idle(3);
        total_cnt++;
        if (wa_q.size() - base != 6 || wa_q[base+5] !== 12'd5 || wd_q[base+5] !== 32'hC4C3C2C1)
            $display("FAIL restart_ignored: got n=%0d addr=%0d required 6 writes, c4c3c2c1 at 5",
                     wa_q.size() - base, wa_q[wa_q.size()-1]);
        else pass_cnt++;
        pulse_stop();
    endtask

    task automatic test_reset_mid_frame();
        int base;
        pulse_start();
        for (int i = 0; i < 42; i++) put_byte(8'h80 + 8'(i));
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({bus.WR_EN, bus.FRAME_DONE, bus.BYTE_ERR, bus.ACTIVE} !== 4'b0 ||
            bus.WR_ADDR !== '0 || bus.WR_DATA !== 32'h0)
            $display("FAIL reset_mid_outputs: got flags=%b addr=%0d data=%h required 0",
                     {bus.WR_EN, bus.FRAME_DONE, bus.BYTE_ERR, bus.ACTIVE}, bus.WR_ADDR, bus.WR_DATA);
        else pass_cnt++;
        base = wa_q.size();
        pulse_start();
        put_byte(8'h55); put_byte(8'h56); put_byte(8'h57); put_byte(8'h58);
        go_idle(3);
        total_cnt++;
        if (wa_q.size() - base != 1 || wa_q[base] !== 12'd0 || wd_q[base] !== 32'h58575655)
            $display("FAIL reset_mid_next: got n=%0d data=%h required 58575655 at 0",
                     wa_q.size() - base, wd_q[wd_q.size()-1]);
        else pass_cnt++;
        pulse_stop();
    endtask

    initial begin
        bus.START    = 1'b0;
        bus.STOP     = 1'b0;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;
        test_reset();
        test_single_word();
        test_full_frame();
        test_timeout();
        test_stop();
        test_start_stop();
        test_restart_ignored();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
